fm_beat_packer: RTL

Upstream feeder for the feature-map mean path. It collects a serial stream of `bitwidth`-wide FP16 feature-map words and packs them into `N`-lane beats. Each beat is presented as `out`/`out_valid`/`out_last` directly on the `in`/`in_valid`/`in_last` inputs of the mean stage. A partial final beat is padded with +0.0, so the downstream sum is unaffected. The block also reports the word count of each frame, which software uses to program `H_param`.

---
 rtl/fm_beat_packer.sv | 103 ++++++++++
 1 files changed

// File: rtl/fm_beat_packer.sv
// Packs a serial stream of FP16 feature-map words into N-lane beats for the mean stage,
// zero-padding the final partial beat and reporting the word count of each frame.
module fm_beat_packer #(
  parameter int bitwidth = 16,
  parameter int N        = 8,
  parameter int LEN_W    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [bitwidth-1:0]     s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic [N*bitwidth-1:0]   out,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [LEN_W-1:0]        frame_len,
  output logic                    frame_len_valid,
  output logic                    len_ovf
);

  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);
  localparam logic [LEN_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_q;
  logic [LANE_W-1:0]       lane_q;
  logic [N*bitwidth-1:0]   acc_q;
  logic [LEN_W-1:0]        wcnt_q;
  logic [N*bitwidth-1:0]   out_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [LEN_W-1:0]        frame_len_q;
  logic                    frame_len_valid_q;
  logic                    len_ovf_q;

  logic [N*bitwidth-1:0]   beat_d;
  logic [LEN_W-1:0]        wcnt_d;
  logic                    beat_done;

  // acc_q is always zero above lane_q, so writing the current lane yields a padded beat.
  always_comb begin
    beat_d = acc_q;
    beat_d[lane_q*bitwidth +: bitwidth] = s_data;
    wcnt_d = (wcnt_q == CNT_MAX) ? CNT_MAX : wcnt_q + LEN_W'(1);
    beat_done = s_valid && (s_last || (lane_q == LAST_LANE));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q           <= IDLE;
      lane_q            <= '0;
      acc_q             <= '0;
      wcnt_q            <= '0;
      out_q             <= '0;
      out_valid_q       <= 1'b0;
      out_last_q        <= 1'b0;
      frame_len_q       <= '0;
      frame_len_valid_q <= 1'b0;
      len_ovf_q         <= 1'b0;
    end else begin
      out_valid_q       <= 1'b0;
      out_last_q        <= 1'b0;
      frame_len_valid_q <= 1'b0;
      if (s_valid) begin
        state_q <= s_last ? IDLE : FILL;
        // Overflow flag is sticky across the frame and cleared only by the next frame's first word.
        if (wcnt_d == CNT_MAX)
          len_ovf_q <= 1'b1;
        else if (state_q == IDLE)
          len_ovf_q <= 1'b0;

        if (beat_done) begin
          out_q       <= beat_d;
          out_valid_q <= 1'b1;
          out_last_q  <= s_last;
          acc_q       <= '0;
          lane_q      <= '0;
        end else begin
          acc_q  <= beat_d;
          lane_q <= lane_q + LANE_W'(1);
        end

        if (s_last) begin
          frame_len_q       <= wcnt_d;
          frame_len_valid_q <= 1'b1;
          wcnt_q            <= '0;
        end else begin
          wcnt_q <= wcnt_d;
        end
      end
    end
  end

  assign out             = out_q;
  assign out_valid       = out_valid_q;
  assign out_last        = out_last_q;
  assign frame_len       = frame_len_q;
  assign frame_len_valid = frame_len_valid_q;
  assign len_ovf         = len_ovf_q;

endmodule
